// File: rtl/mac_acc_bank_pkg.sv
// Shared types and arithmetic helpers for the mac_acc_bank accumulator bank.
// Helpers work on a wide MAX_W container so one definition serves every lane width.
package mac_pkg;

    localparam int DEF_PROD_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 19;
    localparam int MAX_W          = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Sign-extend the low w bits of v to MAX_W bits.
    function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] sh;
        sh = v << (MAX_W - w);
        return $signed(sh) >>> (MAX_W - w);
    endfunction

    function automatic logic out_of_range(input logic signed [MAX_W-1:0] s, input int w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        lo = -$signed(MAX_W'(1) << (w - 1));
        return (s > hi) || (s < lo);
    endfunction

    // Clamp s to the signed range of a w-bit value.
    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] s, input int w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        lo = -$signed(MAX_W'(1) << (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_acc_bank_if.sv
// Control, product and result bundle of mac_acc_bank.
// master drives start/clear/products/out_ready; slave is the accumulator bank.
interface mac_acc_bank_if #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 19,
    parameter int NUM_LANES  = 4,
    parameter int TAP_COUNT  = 8
);
    localparam int CNT_WIDTH = $clog2(TAP_COUNT) + 1;

    logic                            start;
    logic                            clear;
    logic [NUM_LANES*PROD_WIDTH-1:0] prod_in;
    logic                            prod_valid;
    logic [NUM_LANES*ACC_WIDTH-1:0]  acc_out;
    logic                            out_valid;
    logic                            out_ready;
    logic                            busy;
    logic [CNT_WIDTH-1:0]            tap_idx;
    logic [NUM_LANES-1:0]            ovf;

    modport master (
        output start, clear, prod_in, prod_valid, out_ready,
        input  acc_out, out_valid, busy, tap_idx, ovf
    );

    modport slave (
        input  start, clear, prod_in, prod_valid, out_ready,
        output acc_out, out_valid, busy, tap_idx, ovf
    );

endinterface

// File: rtl/mac_acc_lane.sv
// One accumulator lane: sign-extended add, wrap or clamp, sticky overflow flag.
// Optional clamping is enabled by defining MAC_ACC_SATURATE_EN.
module mac_acc_lane
    import mac_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_en_i,
    input  logic                  add_en_i,
    input  logic [PROD_WIDTH-1:0] prod_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  ovf_o
);

    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic signed [MAX_W-1:0] sum_full;

    // sum_full is exact: the wide container holds every ACC_WIDTH+1 bit sum.
    always_comb begin
        sum_full = sext(MAX_W'(acc_q), ACC_WIDTH) + sext(MAX_W'(prod_i), PROD_WIDTH);
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (clr_en_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_en_i) begin
`ifdef MAC_ACC_SATURATE_EN
            acc_d = ACC_WIDTH'(saturate(sum_full, ACC_WIDTH));
            ovf_d = ovf_q | out_of_range(sum_full, ACC_WIDTH);
`else
            acc_d = ACC_WIDTH'(sum_full);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_acc_bank.sv
// Multi-lane tap-counted MAC accumulator bank with valid/ready result handshake.
// Define MAC_ACC_SATURATE_EN to clamp lane sums and raise sticky ovf flags.
module mac_acc_bank
    import mac_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int NUM_LANES  = 4,
    parameter int TAP_COUNT  = 8,
    parameter int CNT_WIDTH  = $clog2(TAP_COUNT) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mac_acc_bank_if.slave bus
);

    if (TAP_COUNT < 1) begin : g_bad_taps
        $error("mac_acc_bank: TAP_COUNT must be at least 1");
    end
    if (ACC_WIDTH + 1 > MAX_W) begin : g_bad_width
        $error("mac_acc_bank: ACC_WIDTH too wide for the helper container");
    end

    localparam logic [CNT_WIDTH-1:0] TAP_LAST = CNT_WIDTH'(TAP_COUNT);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] tap_q, tap_d;
    logic [CNT_WIDTH-1:0] tap_inc;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 clr_en;
    logic                 add_en;

    logic [NUM_LANES*ACC_WIDTH-1:0] acc_all;
    logic [NUM_LANES-1:0]           ovf_all;

    assign tap_inc = tap_q + CNT_WIDTH'(1);

    // clear outranks everything; DONE only moves on once the result is accepted.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        clr_en  = 1'b0;
        add_en  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            tap_d   = '0;
            clr_en  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_ACCUM;
                        tap_d   = '0;
                        clr_en  = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (bus.prod_valid) begin
                        add_en = 1'b1;
                        tap_d  = tap_inc;
                        if (tap_inc == TAP_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        if (bus.start) begin
                            state_d = ST_ACCUM;
                            tap_d   = '0;
                            clr_en  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_ACCUM);
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        mac_acc_lane #(
            .PROD_WIDTH(PROD_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_en_i(clr_en),
            .add_en_i(add_en),
            .prod_i  (bus.prod_in[gi*PROD_WIDTH +: PROD_WIDTH]),
            .acc_o   (acc_all[gi*ACC_WIDTH +: ACC_WIDTH]),
            .ovf_o   (ovf_all[gi])
        );
    end

    assign bus.acc_out   = acc_all;
    assign bus.ovf       = ovf_all;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.tap_idx   = tap_q;

endmodule

// File: tb/tb_mac_acc_bank.sv
// Directed bench for mac_acc_bank: 17-bit lanes, 8 taps, plus a TAP_COUNT=1 instance.
module tb_mac_acc_bank;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    mac_acc_bank_if #(.PROD_WIDTH(16), .ACC_WIDTH(17), .NUM_LANES(4), .TAP_COUNT(8)) bus ();
    mac_acc_bank_if #(.PROD_WIDTH(16), .ACC_WIDTH(17), .NUM_LANES(4), .TAP_COUNT(1)) bus1 ();

    mac_acc_bank #(.PROD_WIDTH(16), .ACC_WIDTH(17), .NUM_LANES(4), .TAP_COUNT(8)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    mac_acc_bank #(.PROD_WIDTH(16), .ACC_WIDTH(17), .NUM_LANES(4), .TAP_COUNT(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [16:0] lane_of(input logic [67:0] v, input int i);
        return v[i*17 +: 17];
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_beats(input logic [63:0] p, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bus.prod_in    = p;
            bus.prod_valid = 1'b1;
            tick();
            bus.prod_valid = 1'b0;
            if (gaps) begin
                bus.prod_in = 64'h7654_3210_1357_2468;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.acc_out !== 68'd0 || bus.tap_idx !== 4'd0 || bus.ovf !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_data: acc=%h tap=%0d ovf=%b required 0/0/0", bus.acc_out, bus.tap_idx, bus.ovf);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: out_valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_window();
        tests_run++;
        if (bus.busy !== 1'b1 || bus.tap_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL basic_start: busy=%b tap=%0d required 1/0", bus.busy, bus.tap_idx);
        end
        drive_beats(pack4(16'd100, 16'd100, 16'd100, 16'd100), 7, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.tap_idx !== 4'd7) begin
            tests_failed++;
            $display("FAIL basic_beat7: out_valid=%b tap=%0d required 0/7", bus.out_valid, bus.tap_idx);
        end
        drive_beats(pack4(16'd100, 16'd100, 16'd100, 16'd100), 1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.tap_idx !== 4'd8) begin
            tests_failed++;
            $display("FAIL basic_done: out_valid=%b busy=%b tap=%0d required 1/0/8",
                     bus.out_valid, bus.busy, bus.tap_idx);
        end
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (lane_of(bus.acc_out, l) !== 17'sd800) begin
                tests_failed++;
                $display("FAIL basic_lane%0d: got %0d required 800", l, lane_of(bus.acc_out, l));
            end
        end
        accept();
        tests_run++;
        if (bus.out_valid !== 1'b0 || lane_of(bus.acc_out, 0) !== 17'sd800) begin
            tests_failed++;
            $display("FAIL basic_accept: out_valid=%b lane0=%0d required 0/800",
                     bus.out_valid, lane_of(bus.acc_out, 0));
        end
        $display("[TB] basic window done");
    endtask

    task automatic test_gapped();
        start_window();
        drive_beats(pack4(16'hFFFB, 16'd7, 16'hFFFF, 16'd0), 3, 1'b1);
        tests_run++;
        if (bus.tap_idx !== 4'd3 || lane_of(bus.acc_out, 0) !== -17'sd15) begin
            tests_failed++;
            $display("FAIL gap_hold: tap=%0d lane0=%0d required 3/-15", bus.tap_idx, lane_of(bus.acc_out, 0));
        end
        drive_beats(pack4(16'hFFFB, 16'd7, 16'hFFFF, 16'd0), 4, 1'b1);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_early: out_valid=%b required 0", bus.out_valid);
        end
        drive_beats(pack4(16'hFFFB, 16'd7, 16'hFFFF, 16'd0), 1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || lane_of(bus.acc_out, 0) !== -17'sd40 ||
            lane_of(bus.acc_out, 1) !== 17'sd56 || lane_of(bus.acc_out, 2) !== -17'sd8 ||
            lane_of(bus.acc_out, 3) !== 17'sd0) begin
            tests_failed++;
            $display("FAIL gap_result: valid=%b lanes=%0d,%0d,%0d,%0d required 1 -40,56,-8,0",
                     bus.out_valid, lane_of(bus.acc_out, 0), lane_of(bus.acc_out, 1),
                     lane_of(bus.acc_out, 2), lane_of(bus.acc_out, 3));
        end
        accept();
        $display("[TB] gapped signed window done");
    endtask

    task automatic test_back_to_back();
        start_window();
        drive_beats(pack4(16'd2, 16'd2, 16'd2, 16'd2), 8, 1'b0);
        bus.start      = 1'b1;
        bus.prod_valid = 1'b1;
        bus.prod_in    = pack4(16'd9, 16'd9, 16'd9, 16'd9);
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || lane_of(bus.acc_out, 3) !== 17'sd16 || bus.tap_idx !== 4'd8) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: valid=%b lane3=%0d tap=%0d required 1/16/8",
                         c, bus.out_valid, lane_of(bus.acc_out, 3), bus.tap_idx);
            end
        end
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.tap_idx !== 4'd0 || bus.acc_out !== 68'd0) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%b valid=%b tap=%0d acc=%h required 1/0/0/0",
                     bus.busy, bus.out_valid, bus.tap_idx, bus.acc_out);
        end
        drive_beats(pack4(16'd1, 16'd1, 16'd1, 16'd1), 8, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || lane_of(bus.acc_out, 2) !== 17'sd8) begin
            tests_failed++;
            $display("FAIL b2b_result: valid=%b lane2=%0d required 1/8", bus.out_valid, lane_of(bus.acc_out, 2));
        end
        accept();
        $display("[TB] backpressure and back-to-back done");
    endtask

    task automatic test_clear();
        start_window();
        drive_beats(pack4(16'd50, 16'd50, 16'd50, 16'd50), 3, 1'b0);
        tests_run++;
        if (bus.tap_idx !== 4'd3 || lane_of(bus.acc_out, 1) !== 17'sd150) begin
            tests_failed++;
            $display("FAIL clear_pre: tap=%0d lane1=%0d required 3/150", bus.tap_idx, lane_of(bus.acc_out, 1));
        end
        bus.clear      = 1'b1;
        bus.start      = 1'b1;
        bus.prod_valid = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.tap_idx !== 4'd0 || bus.acc_out !== 68'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_now: busy=%b tap=%0d acc=%h valid=%b required 0/0/0/0",
                     bus.busy, bus.tap_idx, bus.acc_out, bus.out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.acc_out !== 68'd0) begin
                tests_failed++;
                $display("FAIL clear_idle%0d: valid=%b acc=%h required 0/0", c, bus.out_valid, bus.acc_out);
            end
        end
        bus.prod_valid = 1'b0;
        $display("[TB] clear mid-window done");
    endtask

    task automatic test_overflow();
        logic signed [16:0] exp0;
        logic signed [16:0] exp1;
        logic [3:0]         exp_ovf3;
`ifdef MAC_ACC_SATURATE_EN
        exp0     = 17'sd65535;
        exp1     = -17'sd65536;
        exp_ovf3 = 4'b0011;
`else
        exp0     = -17'sd8;
        exp1     = 17'sd0;
        exp_ovf3 = 4'b0000;
`endif
        start_window();
        drive_beats(pack4(16'h7FFF, 16'h8000, 16'd1, 16'd0), 3, 1'b0);
        tests_run++;
        if (bus.ovf !== exp_ovf3) begin
            tests_failed++;
            $display("FAIL ovf_beat3: ovf=%b required %b", bus.ovf, exp_ovf3);
        end
        drive_beats(pack4(16'h7FFF, 16'h8000, 16'd1, 16'd0), 5, 1'b0);
        tests_run++;
        if (lane_of(bus.acc_out, 0) !== exp0 || lane_of(bus.acc_out, 1) !== exp1 ||
            lane_of(bus.acc_out, 2) !== 17'sd8 || bus.ovf !== exp_ovf3) begin
            tests_failed++;
            $display("FAIL ovf_result: lanes=%0d,%0d,%0d ovf=%b required %0d,%0d,8 ovf=%b",
                     lane_of(bus.acc_out, 0), lane_of(bus.acc_out, 1), lane_of(bus.acc_out, 2),
                     bus.ovf, exp0, exp1, exp_ovf3);
        end
        accept();
        $display("[TB] overflow window done");
    endtask

    task automatic test_async_reset();
        start_window();
        tests_run++;
        if (bus.ovf !== 4'd0) begin
            tests_failed++;
            $display("FAIL ovf_clear_on_start: ovf=%b required 0000", bus.ovf);
        end
        drive_beats(pack4(16'd10, 16'd10, 16'd10, 16'd10), 4, 1'b0);
        tests_run++;
        if (bus.busy !== 1'b1 || lane_of(bus.acc_out, 0) !== 17'sd40 || bus.tap_idx !== 4'd4) begin
            tests_failed++;
            $display("FAIL arst_pre: busy=%b lane0=%0d tap=%0d required 1/40/4",
                     bus.busy, lane_of(bus.acc_out, 0), bus.tap_idx);
        end
        bus.prod_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.acc_out !== 68'd0 || bus.tap_idx !== 4'd0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_now: acc=%h tap=%0d busy=%b valid=%b required 0/0/0/0",
                     bus.acc_out, bus.tap_idx, bus.busy, bus.out_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        bus.prod_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.acc_out !== 68'd0) begin
            tests_failed++;
            $display("FAIL arst_after: valid=%b busy=%b acc=%h required 0/0/0",
                     bus.out_valid, bus.busy, bus.acc_out);
        end
        $display("[TB] asynchronous reset done");
    endtask

    task automatic test_tap1();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tests_run++;
        if (bus1.busy !== 1'b1 || bus1.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tap1_start: busy=%b valid=%b required 1/0", bus1.busy, bus1.out_valid);
        end
        bus1.prod_in    = pack4(16'd3, 16'd0, 16'd0, 16'hFFFE);
        bus1.prod_valid = 1'b1;
        tick();
        bus1.prod_valid = 1'b0;
        tests_run++;
        if (bus1.out_valid !== 1'b1 || bus1.tap_idx !== 1'b1 || lane_of(bus1.acc_out, 0) !== 17'sd3 ||
            lane_of(bus1.acc_out, 3) !== -17'sd2) begin
            tests_failed++;
            $display("FAIL tap1_done: valid=%b tap=%0d lane0=%0d lane3=%0d required 1/1/3/-2",
                     bus1.out_valid, bus1.tap_idx, lane_of(bus1.acc_out, 0), lane_of(bus1.acc_out, 3));
        end
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        tests_run++;
        if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tap1_accept: valid=%b busy=%b required 0/0", bus1.out_valid, bus1.busy);
        end
        $display("[TB] single-tap window done");
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.clear       = 1'b0;
        bus.prod_in     = '0;
        bus.prod_valid  = 1'b0;
        bus.out_ready   = 1'b0;
        bus1.start      = 1'b0;
        bus1.clear      = 1'b0;
        bus1.prod_in    = '0;
        bus1.prod_valid = 1'b0;
        bus1.out_ready  = 1'b0;

        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_clear();
        test_overflow();
        test_async_reset();
        test_tap1();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_acc_bank.md
Name: mac_acc_bank

Overview:
- Multi-lane, tap-counted MAC accumulator bank. It succeeds the single-lane clear/accumulate accumulator mux.
- Takes NUM_LANES signed products per beat and accumulates exactly TAP_COUNT beats per window.
- Presents the per-lane results with a valid/ready handshake.
- Sits between the multiplier array and the output/requantisation stage. Its FSM replaces the external sel_acc control.

Parameters:
- PROD_WIDTH, 16, width of each signed product lane.
- ACC_WIDTH, 19, width of each signed accumulator lane; must satisfy ACC_WIDTH >= PROD_WIDTH + clog2(TAP_COUNT) for guaranteed overflow-free operation.
- NUM_LANES, 4, number of parallel accumulator lanes.
- TAP_COUNT, 8, products accumulated per window; must be >= 1.
- CNT_WIDTH, clog2(TAP_COUNT)+1, width of the tap counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a new window; sampled in IDLE, or in DONE together with the handshake.
- clear  in  1  synchronous abort; returns to IDLE and zeroes all accumulators.
- prod_in  in  NUM_LANES*PROD_WIDTH  packed signed products, lane 0 in the LSBs.
- prod_valid  in  1  prod_in carries a valid beat this cycle.
- acc_out  out  NUM_LANES*ACC_WIDTH  packed signed accumulator values, lane 0 in the LSBs.
- out_valid  out  1  acc_out holds a completed window.
- out_ready  in  1  downstream accepts acc_out.
- busy  out  1  high in ACCUM.
- tap_idx  out  CNT_WIDTH  number of beats accepted in the current window.
- ovf  out  NUM_LANES  per-lane sticky overflow flags.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - acc_out, tap_idx, ovf = 0.
  - out_valid, busy = 0.
- States: IDLE, ACCUM, DONE. All outputs are registered.

- IDLE:
  - start=1: next state ACCUM; accumulators, tap_idx and ovf load 0 (clear-on-start).
  - prod_valid is ignored in IDLE.

- ACCUM:
  - busy=1.
  - Each cycle with prod_valid=1, per lane: acc <= acc + sign_extend(prod_in lane), and tap_idx increments.
  - prod_valid=0: hold acc and tap_idx; gaps are allowed.
  - The beat that brings tap_idx to TAP_COUNT is added, then the next state is DONE.
  - out_valid rises on the cycle after that final beat. Latency from last beat to out_valid = 1 cycle.
  - start is ignored in ACCUM.

- DONE:
  - out_valid=1, busy=0; acc_out, tap_idx and ovf are held stable.
  - out_ready=1 and start=0: next state IDLE, out_valid=0. acc_out keeps its value until the next start.
  - out_ready=1 and start=1: next state ACCUM with accumulators cleared. This gives back-to-back windows with no idle cycle.
  - out_ready=0: stay in DONE. start and prod_valid are ignored.

- clear=1 in any state:
  - next state IDLE.
  - acc_out, tap_idx, ovf = 0; out_valid = 0.
  - clear has priority over start, prod_valid and out_ready.

- Arithmetic:
  - Two's complement throughout.
  - Each sum is computed at ACC_WIDTH+1 bits, then narrowed per the optional feature below.
- TAP_COUNT=1: a single beat moves ACCUM to DONE.
- Reset mid-window: the window is discarded with no output produced.

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined:
  - A lane sum above the maximum clamps to 2^(ACC_WIDTH-1)-1.
  - A lane sum below the minimum clamps to -2^(ACC_WIDTH-1).
  - The lane's ovf bit sets and stays set until the next start, clear or reset.
- Undefined:
  - Sums wrap modulo 2^ACC_WIDTH.
  - ovf is tied to 0.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the sign-extend and saturate helper functions;
  - the default width constants (PROD_WIDTH, ACC_WIDTH).
- One sub-module, mac_acc_lane: a single-lane add/narrow/ovf datapath, instantiated NUM_LANES times. It is clocked by the parent's clk and rst_n and takes clr_en and add_en from the parent FSM.

Test Plan:
- Basic window:
  - Stimulus: start, then 8 beats with all lanes = 100.
  - Required: out_valid one cycle after beat 8, every lane = 800, tap_idx = 8.
- Gapped input and signed values:
  - Stimulus: lane0 = -5 on 8 beats, with prod_valid=0 gaps inserted between beats.
  - Required: lane0 = -40, out_valid timing relative to beat 8 unchanged.
- Backpressure and back-to-back:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, then out_ready=1 with start=1, then 8 beats of 1.
  - Required: acc_out held stable during backpressure; next window gives 8 with no IDLE cycle.
- Clear mid-window:
  - Stimulus: assert clear after 3 beats of 50.
  - Required: IDLE next cycle, acc_out = 0, out_valid never asserts.
- Overflow:
  - Stimulus: 8 beats of lane = 32767 with ACC_WIDTH=17.
  - Required with MAC_ACC_SATURATE_EN: lane = 65535, ovf=1.
  - Required without it: lane equals 262136 mod 2^17 = 131064 interpreted signed (-8), ovf=0.
- Asynchronous reset:
  - Stimulus: drop rst_n between clock edges during ACCUM.
  - Required: outputs zero immediately, state IDLE.
